// File: rtl/occupancy_pkg.sv
// occupancy_pkg: shared states, sensor indices and width helper for the occupancy sequencer
package occupancy_pkg;
  typedef enum logic [2:0] {IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, ERR} state_t;
  localparam int SENSOR_A = 0;
  localparam int SENSOR_B = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction
endpackage

// File: rtl/occupancy_sequencer_sensor_debounce.sv
// sensor_debounce: 2-flop synchronizer plus stable-count debouncer for one beam sensor
module sensor_debounce
  import occupancy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = clog2(DEBOUNCE_CYCLES);
  logic sync1_q, sync2_q, level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    level_d = (sync2_q != level_q && cnt_q == CW'(DEBOUNCE_CYCLES - 1)) ? sync2_q : level_q;
    cnt_d = (sync2_q == level_q || level_d != level_q) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = level_q;
endmodule

// File: rtl/occupancy_sequencer.sv
// occupancy_sequencer: debounced door-beam crossing FSM driving occupancy count and chime
module occupancy_sequencer
  import occupancy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SEQ_TIMEOUT = 100000000,
  parameter int SOUND_CYCLES = 25000000,
  parameter int COUNT_WIDTH = 8,
  parameter int MAX_COUNT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             sensor_in,
  input  logic                   count_clear,
  output logic [COUNT_WIDTH-1:0] amount,
  output logic                   sound_enable,
  output logic                   entry_pulse,
  output logic                   exit_pulse,
  output logic                   seq_error
);
  localparam int TW = clog2(SEQ_TIMEOUT);
  localparam int SW = clog2(SOUND_CYCLES + 1);
  logic [1:0] db;
  state_t state_q, state_d, nxt;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] snd_q, snd_d;
  logic [COUNT_WIDTH-1:0] amount_q, amount_d;
  logic entry_q, entry_d, exit_q, exit_d, err_q, err_d, active, timeout;
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .reset(reset), .din(sensor_in[SENSOR_A]), .dout(db[SENSOR_A])
  );
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .reset(reset), .din(sensor_in[SENSOR_B]), .dout(db[SENSOR_B])
  );
  always_comb begin
    nxt = state_q;
    case (state_q)
      IDLE:    nxt = db == 2'b01 ? IN_A : db == 2'b10 ? OUT_B : db == 2'b11 ? ERR : IDLE;
      IN_A:    nxt = db == 2'b11 ? IN_AB : db == 2'b00 ? IDLE : IN_A;
      IN_AB:   nxt = db == 2'b10 ? IN_B : db == 2'b01 ? IN_A : IN_AB;
      IN_B:    nxt = db == 2'b00 ? IDLE : db == 2'b11 ? IN_AB : IN_B;
      OUT_B:   nxt = db == 2'b11 ? OUT_BA : db == 2'b00 ? IDLE : OUT_B;
      OUT_BA:  nxt = db == 2'b01 ? OUT_A : db == 2'b10 ? OUT_B : OUT_BA;
      OUT_A:   nxt = db == 2'b00 ? IDLE : db == 2'b11 ? OUT_BA : OUT_A;
      default: nxt = db == 2'b00 ? IDLE : ERR;
    endcase
    active = state_q != IDLE && state_q != ERR;
    // a stalled crossing aborts even if the beams happen to change in the same cycle
    timeout = active && timer_q == TW'(SEQ_TIMEOUT - 1);
    state_d = timeout ? ERR : nxt;
    timer_d = (!active || (state_d != state_q && (state_d == IN_A || state_d == OUT_B))) ? '0 : timer_q + 1'b1;
    entry_d = !timeout && state_q == IN_B && nxt == IDLE;
    exit_d = !timeout && state_q == OUT_A && nxt == IDLE;
    err_d = timeout;
    amount_d = count_clear ? '0 :
               (entry_d && amount_q != COUNT_WIDTH'(MAX_COUNT)) ? amount_q + 1'b1 :
               (exit_d && amount_q != '0) ? amount_q - 1'b1 : amount_q;
    snd_d = (entry_d || exit_d) ? SW'(SOUND_CYCLES) : (snd_q != '0) ? snd_q - 1'b1 : snd_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      snd_q <= '0;
      amount_q <= '0;
      entry_q <= 1'b0;
      exit_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      snd_q <= snd_d;
      amount_q <= amount_d;
      entry_q <= entry_d;
      exit_q <= exit_d;
      err_q <= err_d;
    end
  end
  assign amount = amount_q;
  assign sound_enable = snd_q != '0;
  assign entry_pulse = entry_q;
  assign exit_pulse = exit_q;
  assign seq_error = err_q;
endmodule

// File: tb/tb_occupancy_sequencer.sv
// tb_occupancy_sequencer: directed checks of crossing detection, counting, chime, timeout and reset
module tb_occupancy_sequencer;
  import occupancy_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic count_clear = 1'b0;
  logic [1:0] sensor_in = 2'b00;
  logic [7:0] amount;
  logic sound_enable, entry_pulse, exit_pulse, seq_error;
  int total = 0, passed = 0, fails = 0;
  int n_entry = 0, n_exit = 0, n_err = 0, n_snd = 0, n_dba = 0;
  int cyc = 0, ina_cyc = 0, err_cyc = 0;
  int e0, x0, r0, s0, a0;
  state_t prev_state = IDLE;

  occupancy_sequencer #(
    .DEBOUNCE_CYCLES(4), .SEQ_TIMEOUT(64), .SOUND_CYCLES(16), .COUNT_WIDTH(8), .MAX_COUNT(255)
  ) dut (
    .clk(clk), .reset(reset), .sensor_in(sensor_in), .count_clear(count_clear),
    .amount(amount), .sound_enable(sound_enable), .entry_pulse(entry_pulse),
    .exit_pulse(exit_pulse), .seq_error(seq_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    n_entry += int'(entry_pulse);
    n_exit += int'(exit_pulse);
    n_err += int'(seq_error);
    n_snd += int'(sound_enable);
    n_dba += int'(dut.db[0]);
    if (dut.state_q == IN_A && prev_state != IN_A) ina_cyc = cyc;
    if (seq_error) err_cyc = cyc;
    prev_state = dut.state_q;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    sensor_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_entry(input int n);
    hold(2'b01, n); hold(2'b11, n); hold(2'b10, n); hold(2'b00, n);
  endtask

  task automatic do_exit(input int n);
    hold(2'b10, n); hold(2'b11, n); hold(2'b01, n); hold(2'b00, n);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_amount", amount, 0);
    check("rst_sound", sound_enable, 0);
    check("rst_pulses", {entry_pulse, exit_pulse, seq_error}, 0);
    check("rst_state", dut.state_q, IDLE);
    check("rst_db", dut.db, 0);
    // entry
    e0 = n_entry; x0 = n_exit; s0 = n_snd;
    do_entry(10);
    repeat (20) @(negedge clk);
    check("entry_count", n_entry - e0, 1);
    check("entry_no_exit", n_exit - x0, 0);
    check("entry_sound_len", n_snd - s0, 16);
    check("entry_amount", amount, 1);
    // exit from 3, then from 0
    do_entry(10); do_entry(10);
    check("amount_three", amount, 3);
    x0 = n_exit;
    do_exit(10);
    check("exit_count", n_exit - x0, 1);
    check("exit_amount", amount, 2);
    count_clear = 1'b1;
    @(negedge clk);
    count_clear = 1'b0;
    check("clear_amount", amount, 0);
    x0 = n_exit;
    do_exit(10);
    check("exit_floor_pulse", n_exit - x0, 1);
    check("exit_floor_amount", amount, 0);
    // bounce and back-out
    do_entry(10);
    a0 = n_dba; e0 = n_entry; x0 = n_exit;
    for (int i = 0; i < 5; i++) begin
      hold(2'b01, 2); hold(2'b00, 2);
    end
    repeat (4) @(negedge clk);
    check("bounce_no_change", n_dba - a0, 0);
    check("bounce_idle", dut.state_q, IDLE);
    hold(2'b01, 10);
    check("backout_in_a", dut.state_q, IN_A);
    hold(2'b00, 10);
    check("backout_idle", dut.state_q, IDLE);
    check("backout_no_pulse", (n_entry - e0) + (n_exit - x0), 0);
    check("backout_amount", amount, 1);
    // timeout
    e0 = n_entry; x0 = n_exit; r0 = n_err; s0 = n_snd;
    hold(2'b01, 100);
    check("timeout_once", n_err - r0, 1);
    check("timeout_delay", err_cyc - ina_cyc, 64);
    check("timeout_err_state", dut.state_q, ERR);
    hold(2'b00, 10);
    check("timeout_idle", dut.state_q, IDLE);
    check("timeout_amount", amount, 1);
    check("timeout_no_pulse", (n_entry - e0) + (n_exit - x0), 0);
    check("timeout_no_chime", n_snd - s0, 0);
    // saturation and clear priority
    for (int i = 0; i < 254; i++) do_entry(8);
    check("sat_reach", amount, 255);
    e0 = n_entry;
    do_entry(8);
    check("sat_hold", amount, 255);
    check("sat_pulse", n_entry - e0, 1);
    hold(2'b01, 8); hold(2'b11, 8); hold(2'b10, 8);
    sensor_in = 2'b00;
    repeat (5) @(negedge clk);
    check("deb_latency_before", dut.db, 2'b10);
    @(negedge clk);
    check("deb_latency_edge", dut.db, 2'b00);
    count_clear = 1'b1;
    @(negedge clk);
    count_clear = 1'b0;
    check("clear_prio_pulse", entry_pulse, 1);
    check("clear_prio_amount", amount, 0);
    // reset mid-chime
    repeat (20) @(negedge clk);
    hold(2'b01, 8); hold(2'b11, 8); hold(2'b10, 8);
    sensor_in = 2'b00;
    repeat (7) @(negedge clk);
    check("chime_pulse", entry_pulse, 1);
    check("chime_amount", amount, 1);
    repeat (4) @(negedge clk);
    check("chime_on", sound_enable, 1);
    reset = 1'b1;
    sensor_in = 2'b01;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_sound", sound_enable, 0);
    check("midrst_amount", amount, 0);
    check("midrst_state", dut.state_q, IDLE);
    check("midrst_db", dut.db, 0);
    repeat (5) @(negedge clk);
    check("reacq_before", dut.db, 2'b00);
    @(negedge clk);
    check("reacq_edge", dut.db, 2'b01);
    @(negedge clk);
    check("reacq_in_a", dut.state_q, IN_A);
    hold(2'b00, 10);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/occupancy_sequencer.md
Name: occupancy_sequencer

Overview:
- Converts the two raw door-beam sensor inputs into debounced entry/exit events and keeps the room occupancy count.
- Drives the amount/soundenable conduit of the custom PIO that the HPS reads.
- Sits in the FPGA fabric between the sensor pins and the mypio conduit.
- Sensor 0 (A) is the outside beam; sensor 1 (B) is the inside beam.

Parameters:
- DEBOUNCE_CYCLES, 50000: number of consecutive stable cycles before a debounced level changes (1 ms at 50 MHz).
- SEQ_TIMEOUT, 100000000: maximum number of cycles a crossing may stay incomplete (2 s).
- SOUND_CYCLES, 25000000: length of the soundenable pulse (0.5 s).
- COUNT_WIDTH, 8: width of the occupancy counter.
- MAX_COUNT, 255: saturation ceiling, which must be no greater than 2^COUNT_WIDTH-1.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- sensor_in, in, 2: raw beam-broken levels, asynchronous, 1 = beam broken; bit0 = A, bit1 = B.
- count_clear, in, 1: single-cycle synchronous request to zero the count.
- amount, out, COUNT_WIDTH: current occupancy, feeds the mypio conduit amount.
- sound_enable, out, 1: chime enable, feeds the mypio conduit soundenable.
- entry_pulse, out, 1: one-cycle strobe on each completed entry.
- exit_pulse, out, 1: one-cycle strobe on each completed exit.
- seq_error, out, 1: one-cycle strobe when a crossing times out.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset values: amount=0, sound_enable=0, all pulse outputs 0, FSM in IDLE, debounced levels 00, timers 0.
- Input conditioning:
  - Each sensor bit passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any glitch restarts the debounce count.
  - Latency from a raw edge to the debounced edge is DEBOUNCE_CYCLES+2 cycles.
- The FSM runs on the debounced pair {B,A}. Its states and transitions are:
  - IDLE: 01 goes to IN_A; 10 goes to OUT_B; 11 goes to ERR (both beams broken simultaneously).
  - IN_A: 11 goes to IN_AB; 00 goes to IDLE (backed out, no count).
  - IN_AB: 10 goes to IN_B; 01 goes to IN_A.
  - IN_B: 00 goes to IDLE and asserts entry_pulse; 11 goes to IN_AB.
  - OUT_B, OUT_BA and OUT_A mirror IN_A, IN_AB and IN_B with A and B swapped. OUT_A to 00 asserts exit_pulse.
  - Any state other than IDLE or ERR with an unlisted pattern stays put.
  - ERR: waits for 00, then goes to IDLE. No count change.
- Timeout:
  - A cycle counter is cleared on entry to IN_A or OUT_B and runs in all non-IDLE, non-ERR states.
  - When the counter reaches SEQ_TIMEOUT-1, the FSM goes to ERR and seq_error pulses once.
- entry_pulse and exit_pulse are registered and assert in the cycle after the FSM transition. amount updates in that same cycle.
- Counter rules:
  - An entry increments amount, saturating at MAX_COUNT. The pulse still fires at saturation.
  - An exit decrements amount, floored at 0.
  - count_clear takes priority over a same-cycle entry or exit: amount becomes 0 on the next edge, while the pulse still fires.
- Sound:
  - On an entry_pulse or exit_pulse, sound_enable=1 for exactly SOUND_CYCLES cycles.
  - A new event during the chime restarts the full length.
  - seq_error does not chime.
- If reset asserts mid-crossing or mid-chime, every output is at its reset value on the next edge. The debouncers also restart from 00, so a held beam is re-acquired after DEBOUNCE_CYCLES.

Decomposition:
- Package occupancy_pkg holds:
  - the state enum (IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, ERR);
  - the SENSOR_A=0 and SENSOR_B=1 index constants;
  - a function for the timer width, clog2.
- Sub-module sensor_debounce contains the synchronizer, debounce counter and debounced level, with parameter DEBOUNCE_CYCLES. It is instantiated once per sensor bit.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, SEQ_TIMEOUT=64 and SOUND_CYCLES=16.

1. Entry: A, AB, B, 00, each level held 10 cycles. Required: exactly one entry_pulse; amount 0 to 1; sound_enable high for exactly 16 cycles; no exit_pulse.
2. Exit: with amount=3, apply B, BA, A, 00. Required: one exit_pulse; amount=2. Repeat the exit from amount=0: amount stays 0 and the pulse still fires.
3. Bounce and back-out: toggle A every 2 cycles for 20 cycles, then apply A, 00. Required: no debounced change during the toggling, then IN_A then IDLE; no pulse; amount unchanged.
4. Timeout: hold A for 100 cycles. Required: seq_error pulses once, 64 cycles after entering IN_A. Release to 00: FSM returns to IDLE with no count change.
5. Saturation and clear priority: with amount=255, apply an entry. Required: amount stays 255 and entry_pulse fires. Then assert count_clear in the same cycle as a second entry_pulse. Required: amount=0.
6. Reset mid-chime: reset for 1 cycle, 5 cycles into sound_enable. Required: sound_enable=0, amount=0 and FSM in IDLE on the next edge; a held A is re-detected 6 cycles after reset deasserts.
